mem_port_arbiter: RTL and testbench

// Shares the single main-memory port between the instruction cache (read-only line fills)
// and the data cache (line fills and write-backs). Grants one requester at a time and

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_starve_ctr.sv | 39 +++
 rtl/mem_port_arbiter.sv | 116 +++++++++++
 tb/tb_mem_port_arbiter.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants for the memory port arbiter:
// FSM state encoding, owner codes and starvation counter width.
package mem_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      S_IDLE = ST_IDLE,
      S_BUSY = ST_BUSY,
      S_DONE = ST_DONE
   } state_e;

   localparam logic OWNER_I = 1'b0;
   localparam logic OWNER_D = 1'b1;

   localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation counter and winner select for the memory port arbiter.
// Ports: clk, reset (async active-low), ic_req, dc_req, grant (strobe), pick_d.
module mem_arb_starve_ctr
   import mem_arb_pkg::*;
#(
   parameter int STARVE_LIMIT = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic ic_req,
   input  logic dc_req,
   input  logic grant,
   output logic pick_d
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT =
      STARVE_CNT_W'(STARVE_LIMIT);

   logic [STARVE_CNT_W-1:0] r_cnt;
   logic                    w_starved;

   assign w_starved = (r_cnt == LIMIT);

   // D wins ties unless I has been passed over LIMIT times.
   assign pick_d = dc_req & ~(ic_req & w_starved);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
      end else if (grant) begin
         if (pick_d == OWNER_I) begin
            r_cnt <= '0;
         end else if (ic_req && !w_starved) begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one main-memory port between I-cache fills and D-cache fills/write-backs.
// Ports: ic_* / dc_* cache miss interfaces, mem_* memory handshake, busy, owner_d.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int LINE_W       = 128,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              ic_req,
   input  logic [ADDR_W-1:0] ic_addr,
   output logic              ic_ack,
   output logic [LINE_W-1:0] ic_rdata,
   input  logic              dc_req,
   input  logic              dc_we,
   input  logic [ADDR_W-1:0] dc_addr,
   input  logic [LINE_W-1:0] dc_wdata,
   output logic              dc_ack,
   output logic [LINE_W-1:0] dc_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [LINE_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner_d
);

   state_e              r_state;
   state_e              w_state_nxt;
   logic                r_owner_d;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [LINE_W-1:0]   r_mem_wdata;
   logic [LINE_W-1:0]   r_line;
   logic                w_grant;
   logic                w_capture;
   logic                w_pick_d;

   mem_arb_starve_ctr #(
      .STARVE_LIMIT(STARVE_LIMIT)
   ) u_starve (
      .clk    (clk),
      .reset  (reset),
      .ic_req (ic_req),
      .dc_req (dc_req),
      .grant  (w_grant),
      .pick_d (w_pick_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant     = 1'b0;
      w_capture   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (ic_req || dc_req) begin
               w_grant     = 1'b1;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (mem_ready) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end
         end
         S_DONE: w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner_d   <= OWNER_I;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_line      <= '0;
      end else begin
         if (w_grant) begin
            r_owner_d   <= w_pick_d;
            r_mem_we    <= w_pick_d & dc_we;
            r_mem_addr  <= w_pick_d ? dc_addr : ic_addr;
            r_mem_wdata <= w_pick_d ? dc_wdata : '0;
         end
         // Write-backs leave the last fetched line in place.
         if (w_capture && !r_mem_we) begin
            r_line <= mem_rdata;
         end
      end
   end

   assign mem_req   = (r_state == S_BUSY);
   assign busy      = (r_state != S_IDLE);
   assign ic_ack    = (r_state == S_DONE) & (r_owner_d == OWNER_I);
   assign dc_ack    = (r_state == S_DONE) & (r_owner_d == OWNER_D);
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign ic_rdata  = r_line;
   assign dc_rdata  = r_line;
   assign owner_d   = r_owner_d;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed vector table,
// hand sequences for reset/spurious ready, and a randomized run.
module tb_mem_port_arbiter;

   localparam int AW  = 32;
   localparam int LW  = 128;
   localparam int LIM = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          ic_req;
   logic [AW-1:0] ic_addr;
   logic          ic_ack;
   logic [LW-1:0] ic_rdata;
   logic          dc_req;
   logic          dc_we;
   logic [AW-1:0] dc_addr;
   logic [LW-1:0] dc_wdata;
   logic          dc_ack;
   logic [LW-1:0] dc_rdata;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [LW-1:0] mem_wdata;
   logic          mem_ready;
   logic [LW-1:0] mem_rdata;
   logic          busy;
   logic          owner_d;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .LINE_W(LW), .STARVE_LIMIT(LIM)
   ) dut (
      .clk(clk), .reset(reset),
      .ic_req(ic_req), .ic_addr(ic_addr),
      .ic_ack(ic_ack), .ic_rdata(ic_rdata),
      .dc_req(dc_req), .dc_we(dc_we),
      .dc_addr(dc_addr), .dc_wdata(dc_wdata),
      .dc_ack(dc_ack), .dc_rdata(dc_rdata),
      .mem_req(mem_req), .mem_we(mem_we),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy), .owner_d(owner_d)
   );

   int n_chk = 0;
   int n_err = 0;

   // Reference model: pending requests, times I was passed over, last line.
   bit            pend_i, pend_d;
   int            skips;
   logic [LW-1:0] line_m;

   typedef struct {
      bit            ri;
      bit            rd;
      logic [AW-1:0] ia;
      logic [AW-1:0] da;
      bit            we;
      logic [LW-1:0] wd;
      int            dly;
      logic [LW-1:0] rdat;
      bit            spur;
      bit            exp_d;
   } vec_t;

   vec_t tbl[11];

   task automatic chk(input string nm, input logic [LW-1:0] act,
                      input logic [LW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic raise(input bit ri, input bit rd,
                        input logic [AW-1:0] ia, input logic [AW-1:0] da,
                        input bit we, input logic [LW-1:0] wd);
      if (ri && !pend_i) begin
         pend_i  = 1'b1;
         ic_req  = 1'b1;
         ic_addr = ia;
      end
      if (rd && !pend_d) begin
         pend_d   = 1'b1;
         dc_req   = 1'b1;
         dc_addr  = da;
         dc_we    = we;
         dc_wdata = wd;
      end
   endtask

   // One full transaction from IDLE; returns the DUT's owner_d seen in BUSY.
   task automatic run_one(input int dly, input logic [LW-1:0] rdat,
                          input bit spur, output bit got_d);
      bit i_wins;
      i_wins = pend_i && (!pend_d || skips >= LIM);
      if (i_wins) skips = 0;
      else if (pend_i) skips = (skips + 1 > LIM) ? LIM : skips + 1;
      tick();
      got_d = owner_d;
      chk("grant_mem_req", mem_req, 1);
      chk("grant_busy", busy, 1);
      chk("grant_owner", owner_d, !i_wins);
      chk("grant_we", mem_we, i_wins ? 1'b0 : dc_we);
      chk("grant_addr", mem_addr, i_wins ? ic_addr : dc_addr);
      chk("grant_wdata", mem_wdata, i_wins ? '0 : dc_wdata);
      for (int w = 0; w < dly; w++) begin
         tick();
         chk("wait_mem_req", mem_req, 1);
         chk("wait_acks", {ic_ack, dc_ack}, 0);
      end
      mem_ready = 1'b1;
      mem_rdata = rdat;
      tick();
      if (i_wins || !dc_we) line_m = rdat;
      chk("done_ic_ack", ic_ack, i_wins);
      chk("done_dc_ack", dc_ack, !i_wins);
      chk("done_ic_rdata", ic_rdata, line_m);
      chk("done_dc_rdata", dc_rdata, line_m);
      chk("done_mem_req", mem_req, 0);
      chk("done_busy", busy, 1);
      if (!spur) mem_ready = 1'b0;
      if (i_wins) begin
         ic_req = 1'b0;
         pend_i = 1'b0;
      end else begin
         dc_req = 1'b0;
         pend_d = 1'b0;
      end
      tick();
      mem_ready = 1'b0;
      chk("idle_busy", busy, 0);
      chk("idle_acks", {ic_ack, dc_ack}, 0);
      chk("idle_mem_req", mem_req, 0);
   endtask

   initial begin
      bit            got_d;
      bit            ri, rd, we, sp;
      logic [LW-1:0] wd, rv;
      logic [AW-1:0] ia, da;

      reset = 1'b0;
      ic_req = 0; ic_addr = '0;
      dc_req = 0; dc_we = 0; dc_addr = '0; dc_wdata = '0;
      mem_ready = 0; mem_rdata = '0;
      pend_i = 0; pend_d = 0; skips = 0; line_m = '0;

      #3;
      chk("rst_busy", busy, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_acks", {ic_ack, dc_ack}, 0);
      chk("rst_owner", owner_d, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_rdata", ic_rdata, 0);
      #9 reset = 1'b1;
      tick();

      // Reset while a transaction is outstanding.
      raise(1, 0, 32'h77, '0, 0, '0);
      tick();
      chk("mid_mem_req", mem_req, 1);
      #2 reset = 1'b0;
      #1;
      chk("arst_mem_req", mem_req, 0);
      chk("arst_busy", busy, 0);
      chk("arst_acks", {ic_ack, dc_ack}, 0);
      chk("arst_addr", mem_addr, 0);
      ic_req = 0; pend_i = 0; skips = 0; line_m = '0;
      #2 reset = 1'b1;
      tick();
      chk("post_rst_busy", busy, 0);

      // Spurious mem_ready while idle.
      mem_ready = 1'b1;
      tick();
      tick();
      chk("spur_idle_busy", busy, 0);
      chk("spur_idle_acks", {ic_ack, dc_ack}, 0);
      mem_ready = 1'b0;

      tbl[0]  = '{1, 0, 32'h100, 32'h0, 0, 128'h0, 3,
                  128'hDEAD0000_11112222_33334444_5555BEEF, 0, 0};
      tbl[1]  = '{0, 1, 32'h0, 32'h2000, 1,
                  128'hA5A5A5A5_A5A5A5A5_A5A5A5A5_A5A5A5A5, 1,
                  128'h11111111_11111111_11111111_11111111, 0, 1};
      tbl[2]  = '{1, 1, 32'h140, 32'h3000, 0, 128'h0, 0,
                  128'h22222222_0000FFFF_22222222_0000FFFF, 0, 1};
      tbl[3]  = '{0, 0, 32'h0, 32'h0, 0, 128'h0, 2,
                  128'h33333333_33333333_CCCCCCCC_CCCCCCCC, 1, 0};
      tbl[4]  = '{1, 1, 32'h180, 32'h4000, 0, 128'h0, 0,
                  128'h44444444_44444444_44444444_44444444, 0, 1};
      tbl[5]  = '{0, 1, 32'h0, 32'h4040, 1, 128'h5A5A, 1,
                  128'h55555555_55555555_55555555_55555555, 0, 1};
      tbl[6]  = '{0, 1, 32'h0, 32'h4080, 0, 128'h0, 0,
                  128'h66666666_66666666_66666666_66666666, 0, 1};
      tbl[7]  = '{0, 1, 32'h0, 32'h40C0, 0, 128'h0, 1,
                  128'h77777777_77777777_77777777_77777777, 0, 0};
      tbl[8]  = '{0, 0, 32'h0, 32'h0, 0, 128'h0, 0,
                  128'h88888888_88888888_88888888_88888888, 0, 1};
      tbl[9]  = '{1, 1, 32'h1C0, 32'h5000, 0, 128'h0, 2,
                  128'h99999999_99999999_99999999_99999999, 0, 1};
      tbl[10] = '{0, 0, 32'h0, 32'h0, 0, 128'h0, 0,
                  128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 1, 0};

      for (int k = 0; k < 11; k++) begin
         raise(tbl[k].ri, tbl[k].rd, tbl[k].ia, tbl[k].da,
               tbl[k].we, tbl[k].wd);
         run_one(tbl[k].dly, tbl[k].rdat, tbl[k].spur, got_d);
         chk($sformatf("vec%0d_winner", k), got_d, tbl[k].exp_d);
      end

      for (int it = 0; it < 80; it++) begin
         ri = 1'($urandom_range(1, 0));
         rd = 1'($urandom_range(1, 0));
         we = 1'($urandom_range(1, 0));
         sp = 1'($urandom_range(1, 0));
         ia = $urandom();
         da = $urandom();
         wd = {$urandom(), $urandom(), $urandom(), $urandom()};
         rv = {$urandom(), $urandom(), $urandom(), $urandom()};
         raise(ri, rd, ia, da, we, wd);
         if (!pend_i && !pend_d) begin
            mem_ready = sp;
            tick();
            chk("rnd_idle_busy", busy, 0);
            chk("rnd_idle_acks", {ic_ack, dc_ack}, 0);
            mem_ready = 1'b0;
         end else begin
            run_one($urandom_range(3, 0), rv, sp, got_d);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
